// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one line-wide memory port between an icache
// (line fills only) and a dcache (fills and writebacks).
// One transaction is in flight at a time. The memory-side request is built
// from registers and held until the memory acks. The caches get
// combinational acks, and read data is passed straight through.
// Optional build macro: ARB_ROUND_ROBIN_EN
//   - defined:   ties alternate between the two requesters
//   - undefined: the dcache always wins ties
module cache_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 128
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              icache2arb_req_i,
   input  logic [ADDR_W-1:0] icache2arb_addr_i,
   output logic              arb2icache_ack_o,
   input  logic              dcache2arb_req_i,
   input  logic              dcache2arb_we_i,
   input  logic [ADDR_W-1:0] dcache2arb_addr_i,
   input  logic [LINE_W-1:0] dcache2arb_wdata_i,
   output logic              arb2dcache_ack_o,
   output logic [LINE_W-1:0] arb2cache_rdata_o,
   output logic              arb2mem_req_o,
   output logic              arb2mem_we_o,
   output logic [ADDR_W-1:0] arb2mem_addr_o,
   output logic [LINE_W-1:0] arb2mem_wdata_o,
   input  logic              mem2arb_ack_i,
   input  logic [LINE_W-1:0] mem2arb_rdata_i
);

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ICACHE = 2'd1,
      ARB_DCACHE = 2'd2
   } arb_state_t;

   arb_state_t state;
   logic       last_grant;   // 0 = icache, 1 = dcache
   logic       any_req;
   logic       pick_dcache;

   assign any_req = icache2arb_req_i | dcache2arb_req_i;

   // Choose the winner for a grant taken in ARB_IDLE
   always_comb begin
      pick_dcache = 1'b0;
      if (icache2arb_req_i && dcache2arb_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
         pick_dcache = ~last_grant;
`else
         pick_dcache = 1'b1;
`endif
      end else if (dcache2arb_req_i) begin
         pick_dcache = 1'b1;
      end else begin
         pick_dcache = 1'b0;
      end
   end

`ifndef ARB_ROUND_ROBIN_EN
   // Fixed priority never consults last_grant. It is still tracked so the
   // same state exists in both builds.
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
`endif

   // Arbitration FSM: latch the winner's request into the memory-side
   // registers and hold them until the memory acks
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state           <= ARB_IDLE;
         last_grant      <= 1'b0;
         arb2mem_req_o   <= 1'b0;
         arb2mem_we_o    <= 1'b0;
         arb2mem_addr_o  <= {ADDR_W{1'b0}};
         arb2mem_wdata_o <= {LINE_W{1'b0}};
      end else begin
         case (state)
            ARB_IDLE: begin
               // A memory ack that arrives while idle is stale; ignore it
               if (any_req) begin
                  last_grant    <= pick_dcache;
                  arb2mem_req_o <= 1'b1;
                  if (pick_dcache) begin
                     state           <= ARB_DCACHE;
                     arb2mem_we_o    <= dcache2arb_we_i;
                     arb2mem_addr_o  <= dcache2arb_addr_i;
                     arb2mem_wdata_o <= dcache2arb_wdata_i;
                  end else begin
                     state           <= ARB_ICACHE;
                     arb2mem_we_o    <= 1'b0;
                     arb2mem_addr_o  <= icache2arb_addr_i;
                     arb2mem_wdata_o <= {LINE_W{1'b0}};
                  end
               end else begin
                  state <= ARB_IDLE;
               end
            end
            ARB_ICACHE, ARB_DCACHE: begin
               // Never abort a memory transaction, even if the icache has
               // killed its fetch; wait for the ack
               if (mem2arb_ack_i) begin
                  state         <= ARB_IDLE;
                  arb2mem_req_o <= 1'b0;
               end else begin
                  state <= state;
               end
            end
            default: begin
               state         <= ARB_IDLE;
               arb2mem_req_o <= 1'b0;
            end
         endcase
      end
   end

   // The icache ack is masked when the fetch was killed mid-transaction
   assign arb2icache_ack_o  = mem2arb_ack_i & (state == ARB_ICACHE) & icache2arb_req_i;
   assign arb2dcache_ack_o  = mem2arb_ack_i & (state == ARB_DCACHE);
   assign arb2cache_rdata_o = mem2arb_rdata_i;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Testbench for cache_mem_arbiter: directed scenarios followed by random
// traffic. Outputs are checked against a transaction-level reference model.
module tb_cache_mem_arbiter;

   localparam int AW = 32;
   localparam int LW = 128;

   logic          clk = 1'b0;
   logic          rst;
   logic          icache2arb_req_i;
   logic [AW-1:0] icache2arb_addr_i;
   logic          arb2icache_ack_o;
   logic          dcache2arb_req_i;
   logic          dcache2arb_we_i;
   logic [AW-1:0] dcache2arb_addr_i;
   logic [LW-1:0] dcache2arb_wdata_i;
   logic          arb2dcache_ack_o;
   logic [LW-1:0] arb2cache_rdata_o;
   logic          arb2mem_req_o;
   logic          arb2mem_we_o;
   logic [AW-1:0] arb2mem_addr_o;
   logic [LW-1:0] arb2mem_wdata_o;
   logic          mem2arb_ack_i;
   logic [LW-1:0] mem2arb_rdata_i;

   int total = 0;
   int bad   = 0;

   // Reference model: whether a transaction is open, who owns it, and its contents
   bit            m_busy;
   bit            m_owner;      // 1 = dcache
   bit            m_last;
   bit            m_we;
   logic [AW-1:0] m_addr;
   logic [LW-1:0] m_wdata;
   bit            last_d_ack;

   cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .icache2arb_req_i   (icache2arb_req_i),
      .icache2arb_addr_i  (icache2arb_addr_i),
      .arb2icache_ack_o   (arb2icache_ack_o),
      .dcache2arb_req_i   (dcache2arb_req_i),
      .dcache2arb_we_i    (dcache2arb_we_i),
      .dcache2arb_addr_i  (dcache2arb_addr_i),
      .dcache2arb_wdata_i (dcache2arb_wdata_i),
      .arb2dcache_ack_o   (arb2dcache_ack_o),
      .arb2cache_rdata_o  (arb2cache_rdata_o),
      .arb2mem_req_o      (arb2mem_req_o),
      .arb2mem_we_o       (arb2mem_we_o),
      .arb2mem_addr_o     (arb2mem_addr_o),
      .arb2mem_wdata_o    (arb2mem_wdata_o),
      .mem2arb_ack_i      (mem2arb_ack_i),
      .mem2arb_rdata_i    (mem2arb_rdata_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy  = 1'b0;
      m_owner = 1'b0;
      m_last  = 1'b0;
      m_we    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
   endtask

   // Advance the model by one clock edge, using the inputs presented in that cycle
   task automatic model_step();
      bit d;
      last_d_ack = 1'b0;
      if (rst) begin
         model_reset();
      end else if (m_busy) begin
         if (mem2arb_ack_i) begin
            last_d_ack = m_owner;
            m_busy     = 1'b0;
         end
      end else if (icache2arb_req_i || dcache2arb_req_i) begin
         if (icache2arb_req_i && dcache2arb_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
            d = !m_last;
`else
            d = 1'b1;
`endif
         end else begin
            d = dcache2arb_req_i;
         end
         m_busy  = 1'b1;
         m_owner = d;
         m_last  = d;
         m_we    = d ? dcache2arb_we_i : 1'b0;
         m_addr  = d ? dcache2arb_addr_i : icache2arb_addr_i;
         m_wdata = d ? dcache2arb_wdata_i : '0;
      end
   endtask

   task automatic check_outputs();
      chk("mem_req", arb2mem_req_o, m_busy);
      if (m_busy) begin
         chk("mem_addr", arb2mem_addr_o, m_addr);
         chk("mem_we", arb2mem_we_o, m_we);
         chk("mem_wdata", arb2mem_wdata_o, m_wdata);
      end
      chk("icache_ack", arb2icache_ack_o,
          mem2arb_ack_i & m_busy & !m_owner & icache2arb_req_i);
      chk("dcache_ack", arb2dcache_ack_o, mem2arb_ack_i & m_busy & m_owner);
      chk("rdata", arb2cache_rdata_o, mem2arb_rdata_i);
   endtask

   // One cycle: check at the falling edge, update the model at the rising edge, then step just past it
   task automatic tick();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      #1;
      chk("rst_req", arb2mem_req_o, 1'b0);
      chk("rst_we", arb2mem_we_o, 1'b0);
      chk("rst_addr", arb2mem_addr_o, '0);
      chk("rst_wdata", arb2mem_wdata_o, '0);
      chk("rst_iack", arb2icache_ack_o, 1'b0);
      chk("rst_dack", arb2dcache_ack_o, 1'b0);
      tick();
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0] exp_order;
      logic [AW-1:0] iaddr_c;
      logic [AW-1:0] daddr_c;
      bit d_hold;

      rst = 1'b0;
      icache2arb_req_i = 1'b0; icache2arb_addr_i = '0;
      dcache2arb_req_i = 1'b0; dcache2arb_we_i = 1'b0;
      dcache2arb_addr_i = '0;  dcache2arb_wdata_i = '0;
      mem2arb_ack_i = 1'b0;    mem2arb_rdata_i = '0;
      model_reset();
      @(posedge clk); #1;
      mem2arb_ack_i = 1'b1;    // the acks must stay low during reset even with a memory ack present
      do_reset();
      mem2arb_ack_i = 1'b0;
      tick();

      // Icache fill alone; the memory acks in the third request cycle
      icache2arb_req_i  = 1'b1;
      icache2arb_addr_i = 32'h8000_0040;
      mem2arb_rdata_i   = {4{32'hCAFE_F00D}};
      tick();                       // grant at edge N
      tick(); tick();               // request high in N+1 and N+2
      mem2arb_ack_i = 1'b1;
      tick();                       // ack in N+3
      mem2arb_ack_i = 1'b0; icache2arb_req_i = 1'b0;
      tick();

      // A memory ack while idle is ignored
      mem2arb_ack_i = 1'b1;
      tick();
      mem2arb_ack_i = 1'b0;

      // Dcache writeback
      dcache2arb_req_i   = 1'b1;
      dcache2arb_we_i    = 1'b1;
      dcache2arb_addr_i  = 32'h8000_1000;
      dcache2arb_wdata_i = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
      icache2arb_req_i   = 1'b0;
      tick(); tick();
      mem2arb_ack_i = 1'b1;
      tick();
      mem2arb_ack_i = 1'b0; dcache2arb_req_i = 1'b0;
      tick();

      // Both caches request every cycle for four transactions
      do_reset();
`ifdef ARB_ROUND_ROBIN_EN
      exp_order = 4'b0101;          // bit k = 1 means dcache wins grant k: D,I,D,I
`else
      exp_order = 4'b1111;          // D,D,D,D
`endif
      iaddr_c = 32'h0000_1100;
      daddr_c = 32'h0000_2200;
      icache2arb_req_i = 1'b1; icache2arb_addr_i = iaddr_c;
      dcache2arb_req_i = 1'b1; dcache2arb_we_i = 1'b0; dcache2arb_addr_i = daddr_c;
      dcache2arb_wdata_i = '0;
      for (int k = 0; k < 4; k++) begin
         tick();                    // grant
         chk($sformatf("tie_order_%0d", k), (arb2mem_addr_o == daddr_c), exp_order[k]);
         mem2arb_ack_i = 1'b1;
         tick();
         mem2arb_ack_i = 1'b0;
      end
      icache2arb_req_i = 1'b0; dcache2arb_req_i = 1'b0;
      tick();

      // Fetch kill: the icache drops its request one cycle after the grant
      icache2arb_req_i = 1'b1; icache2arb_addr_i = 32'h0000_3300;
      tick();                       // icache granted
      icache2arb_req_i = 1'b0;
      dcache2arb_req_i = 1'b1; dcache2arb_we_i = 1'b1; dcache2arb_addr_i = 32'h0000_4400;
      dcache2arb_wdata_i = {4{32'h5A5A_A5A5}};
      tick(); tick(); tick();
      mem2arb_ack_i = 1'b1;
      tick();                       // ack with the icache ack suppressed
      mem2arb_ack_i = 1'b0;
      tick();                       // idle cycle; dcache granted at its end
      chk("kill_then_dcache", arb2mem_addr_o, 32'h0000_4400);
      mem2arb_ack_i = 1'b1;
      tick();
      mem2arb_ack_i = 1'b0; dcache2arb_req_i = 1'b0;
      tick();

      // Reset in the middle of a dcache transaction, then a late memory ack
      dcache2arb_req_i = 1'b1; dcache2arb_we_i = 1'b0; dcache2arb_addr_i = 32'h0000_5500;
      tick(); tick();
      chk("pre_rst_busy", arb2mem_req_o, 1'b1);
      do_reset();
      dcache2arb_req_i = 1'b0;
      mem2arb_ack_i = 1'b1;
      tick();
      mem2arb_ack_i = 1'b0;
      tick();

      // Random traffic; the dcache holds its request until it is acked
      d_hold = 1'b0;
      for (int c = 0; c < 400; c++) begin
         icache2arb_req_i  = ($urandom_range(0, 3) != 0);
         icache2arb_addr_i = $urandom;
         if (!d_hold) begin
            dcache2arb_req_i   = ($urandom_range(0, 2) == 0);
            dcache2arb_we_i    = 1'($urandom_range(0, 1));
            dcache2arb_addr_i  = $urandom;
            dcache2arb_wdata_i = {$urandom, $urandom, $urandom, $urandom};
         end
         mem2arb_ack_i   = ($urandom_range(0, 2) == 0);
         mem2arb_rdata_i = {$urandom, $urandom, $urandom, $urandom};
         tick();
         d_hold = dcache2arb_req_i && !last_d_ack;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory byte address width.
REQ-002 SHALL have parameter LINE_W, default 128, cache line width in bits.
REQ-003 SHALL have ports clk_i (input, 1), the single clock, and rst_i (input, 1), the reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have icache2arb_req_i, input, 1: icache line-fill request.
REQ-005 SHALL have icache2arb_addr_i, input, ADDR_W: icache line address.
REQ-006 SHALL have arb2icache_ack_o, output, 1: icache fill complete; read data valid.
REQ-007 SHALL have dcache2arb_req_i, input, 1: dcache request.
REQ-008 SHALL have dcache2arb_we_i, input, 1: dcache writeback (1) or fill (0).
REQ-009 SHALL have dcache2arb_addr_i, input, ADDR_W: dcache line address.
REQ-010 SHALL have dcache2arb_wdata_i, input, LINE_W: dcache writeback data.
REQ-011 SHALL have arb2dcache_ack_o, output, 1: dcache transaction complete.
REQ-012 SHALL have arb2cache_rdata_o, output, LINE_W: memory read data, broadcast to both caches.
REQ-013 SHALL have arb2mem_req_o, arb2mem_we_o (output, 1 each): memory request and write enable.
REQ-014 SHALL have arb2mem_addr_o (output, ADDR_W) and arb2mem_wdata_o (output, LINE_W): memory address and write data.
REQ-015 SHALL have mem2arb_ack_i (input, 1) and mem2arb_rdata_i (input, LINE_W): memory completion and read data.

Function
REQ-016 SHALL implement states ARB_IDLE, ARB_ICACHE and ARB_DCACHE.
REQ-017 In ARB_IDLE with a request present, SHALL register grant, address, we and wdata at clock edge N; arb2mem_req_o asserts in cycle N+1 from the busy state.
REQ-018 SHALL drive arb2mem_req_o, arb2mem_addr_o, arb2mem_we_o and arb2mem_wdata_o from registers only.
REQ-019 SHALL hold those four outputs stable in the busy state until mem2arb_ack_i.
REQ-020 Icache grants SHALL drive arb2mem_we_o=0 and arb2mem_wdata_o=0.
REQ-021 SHALL generate acks combinationally: arb2icache_ack_o = mem2arb_ack_i & state==ARB_ICACHE & icache2arb_req_i; arb2dcache_ack_o = mem2arb_ack_i & state==ARB_DCACHE.
REQ-022 SHALL connect arb2cache_rdata_o = mem2arb_rdata_i (pass-through).
REQ-023 On mem2arb_ack_i in a busy state, SHALL return to ARB_IDLE; the earliest next grant is registered on the following edge (one idle cycle minimum between transactions).
REQ-024 If icache2arb_req_i drops while in ARB_ICACHE (fetch kill), SHALL keep arb2mem_req_o asserted until mem2arb_ack_i; the memory transaction is never aborted.
REQ-025 In the REQ-024 case, SHALL suppress arb2icache_ack_o and return to ARB_IDLE on the ack.
REQ-026 Dcache SHALL hold dcache2arb_req_i and its inputs stable until arb2dcache_ack_o; the arbiter does not check this.
REQ-027 Requests arriving in a busy state SHALL wait, with no loss, and SHALL be evaluated in ARB_IDLE.
REQ-028 mem2arb_ack_i in ARB_IDLE SHALL be ignored; no ack output and no state change.
REQ-029 SHALL register last_grant (0=icache, 1=dcache) at every grant.

Reset
REQ-030 rst_i assertion SHALL force ARB_IDLE immediately.
REQ-031 rst_i assertion SHALL clear arb2mem_req_o, arb2mem_we_o, arb2mem_addr_o, arb2mem_wdata_o and last_grant to 0 immediately.
REQ-032 Both ack outputs SHALL be 0 during reset.
REQ-033 Reset mid-transaction SHALL drop the transaction; a late mem2arb_ack_i arriving in ARB_IDLE is ignored per REQ-028.

Configuration
REQ-034 Macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy when both requests are present in ARB_IDLE.
REQ-035 With ARB_ROUND_ROBIN_EN defined: grant the requester not in last_grant; after reset, last_grant=0, so dcache wins the first tie.
REQ-036 Without ARB_ROUND_ROBIN_EN: dcache always wins ties (fixed priority); last_grant is still maintained.
REQ-037 A single requester SHALL be granted in both configurations.

Verification
REQ-038 Icache alone, addr 0x8000_0040, memory acks 3 cycles after req -> arb2mem_req_o high cycles N+1..N+3, addr 0x8000_0040, we=0, arb2icache_ack_o one cycle coincident with ack.
REQ-039 Dcache writeback, addr 0x8000_1000, wdata 0xDEAD..BEEF -> arb2mem_we_o=1, wdata matches, arb2dcache_ack_o on ack, arb2icache_ack_o stays 0.
REQ-040 Both requesting every cycle for 4 transactions, round-robin build -> grant order D,I,D,I; fixed build -> D,D,D,D.
REQ-041 Icache req dropped 1 cycle after grant, ack 4 cycles later -> arb2mem_req_o held until ack, no arb2icache_ack_o, IDLE next cycle, then pending dcache granted.
REQ-042 rst_i asserted mid ARB_DCACHE, ack arrives after release -> arb2mem_req_o 0 at once, no ack output, state ARB_IDLE.
